regs_port_arbiter: RTL

Round-robin arbiter that shares the register file's single write port and single read port between `NREQ` requesters, such as the writeback stage and the load unit.
- Sits directly in front of `regs`: drives `write_en`/`write_reg`/`write_data` and `read_en`/`read_reg`, and samples `read_out_data`.
- Returns read results as a tagged, registered response one cycle after grant.
- Resolves same-cycle write/read conflicts on the same register by bypass or by deferral.

---
 rtl/regs_pkg.sv | 38 +++
 rtl/regs_port_arbiter_rr_arbiter.sv | 49 ++++
 rtl/regs_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared register-file constants, winning-port record and the round-robin pick
// function used by both arbiters in front of the regfile.
package regs_pkg;

   localparam int REG_AW  = 5;
   localparam int REG_DW  = 32;
   localparam int REG_NUM = 32;

   // Widest requester vector the pick function handles; callers zero-extend.
   localparam int RR_MAXN = 8;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } reg_wr_t;

   // One-hot grant for the first set bit of req scanning ptr, ptr+1, ... mod n.
   // ptr must be below n.
   function automatic logic [RR_MAXN-1:0] rr_pick(input logic [RR_MAXN-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
      logic [RR_MAXN-1:0] gnt;
      logic               found;
      logic [3:0]         idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < RR_MAXN; i++) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= 4'(n)) idx = idx - 4'(n);
         if ((i < n) && !found && req[idx[2:0]]) begin
            gnt[idx[2:0]] = 1'b1;
            found         = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/regs_port_arbiter_rr_arbiter.sv
// Single round-robin arbiter with one rotating pointer; kill suppresses the
// grant for a cycle without advancing the pointer.
module rr_arbiter
   import regs_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            kill,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  cand_id
);

   logic [IDW-1:0]     ptr_q;
   logic [RR_MAXN-1:0] req_w;
   logic [RR_MAXN-1:0] pick_w;
   logic [2:0]         ptr_w;
   logic [NREQ-1:0]    cand;
   logic               unused_pick;

   always_comb begin
      req_w             = '0;
      req_w[NREQ-1:0]   = req;
      ptr_w             = '0;
      ptr_w[IDW-1:0]    = ptr_q;
      pick_w            = rr_pick(req_w, ptr_w, NREQ);
      cand              = pick_w[NREQ-1:0];
      cand_id           = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (cand[i]) cand_id = IDW'(i);
      end
      // Grants are forced low while reset is held so nothing reaches the regfile.
      gnt = (rst_n && !kill) ? cand : '0;
   end

   assign unused_pick = ^pick_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (|gnt) begin
         ptr_q <= (int'(cand_id) == NREQ - 1) ? '0 : cand_id + IDW'(1);
      end
   end

endmodule

// File: rtl/regs_port_arbiter.sv
// Round-robin sharing of the regfile write and read ports between NREQ requesters.
// Optional macro REGS_BYPASS_EN: same-cycle same-register write/read is bypassed
// instead of deferring the read by one cycle.
module regs_port_arbiter
   import regs_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        wr_req,
   input  logic [NREQ*REG_AW-1:0] wr_addr,
   input  logic [NREQ*REG_DW-1:0] wr_data,
   output logic [NREQ-1:0]        wr_gnt,
   input  logic [NREQ-1:0]        rd_req,
   input  logic [NREQ*REG_AW-1:0] rd_addr,
   output logic [NREQ-1:0]        rd_gnt,
   output logic                   rd_rsp_valid,
   output logic [IDW-1:0]         rd_rsp_id,
   output logic [REG_DW-1:0]      rd_rsp_data,
   output logic                   rf_write_en,
   output logic [REG_AW-1:0]      rf_write_reg,
   output logic [REG_DW-1:0]      rf_write_data,
   output logic                   rf_read_en,
   output logic [REG_AW-1:0]      rf_read_reg,
   input  logic [REG_DW-1:0]      rf_read_data
);

   // Handshake: a requester raises req with stable addr/data and holds them until
   // the same-cycle gnt bit is seen high; the transfer happens in that cycle.

   logic [IDW-1:0]    wr_id;
   logic [IDW-1:0]    rd_id;
   logic              wr_any;
   logic              rd_any;
   logic              rd_kill;
   logic              rd_bypass;
   logic [REG_AW-1:0] rd_cand_addr;
   reg_wr_t           wr_win;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_wr_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (wr_req),
      .kill    (1'b0),
      .gnt     (wr_gnt),
      .cand_id (wr_id)
   );

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rd_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (rd_req),
      .kill    (rd_kill),
      .gnt     (rd_gnt),
      .cand_id (rd_id)
   );

   always_comb begin
      wr_win       = '0;
      rd_cand_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (wr_id == IDW'(i)) begin
            wr_win.addr = wr_addr[i*REG_AW +: REG_AW];
            wr_win.data = wr_data[i*REG_DW +: REG_DW];
         end
         if (rd_id == IDW'(i)) begin
            rd_cand_addr = rd_addr[i*REG_AW +: REG_AW];
         end
      end
   end

   assign wr_any = |wr_gnt;
   assign rd_any = |rd_gnt;

   // The regfile reads on the negedge before the write commits, so a matching
   // pair in the same cycle would return the old value.
`ifdef REGS_BYPASS_EN
   assign rd_kill   = 1'b0;
   assign rd_bypass = wr_any && rd_any && (rd_cand_addr == wr_win.addr);
`else
   assign rd_kill   = wr_any && (rd_cand_addr == wr_win.addr);
   assign rd_bypass = 1'b0;
`endif

   assign rf_write_en   = wr_any;
   assign rf_write_reg  = wr_win.addr;
   assign rf_write_data = wr_win.data;
   assign rf_read_en    = rd_any;
   assign rf_read_reg   = rd_cand_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_id    <= '0;
         rd_rsp_data  <= '0;
      end else begin
         rd_rsp_valid <= rd_any;
         if (rd_any) begin
            rd_rsp_id   <= rd_id;
            rd_rsp_data <= rd_bypass ? wr_win.data : rf_read_data;
         end
      end
   end

endmodule
